port_bank: RTL and testbench

PORT_BANK -- requirements
Module: port_bank

---
 rtl/port_bank.sv | 137 +++++++++++++
 tb/tb_port_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/port_bank.sv
// Quasi-bidirectional GPIO bank: per-port output latches, two-flop pad synchronisers, byte/bit access.
// Optional falling-edge pending flags and interrupt when PORT_EDGE_IRQ_EN is defined.
module port_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NPORTS = 4,
  parameter int unsigned SELW   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SELW-1:0]          sel,
  input  logic                     en,
  input  logic                     oe,
  input  logic                     rd_latch,
  input  logic                     Bb,
  input  logic [WIDTH-1:0]         position,
  input  logic [WIDTH-1:0]         din,
  input  logic                     bin,
  output logic [WIDTH-1:0]         dout,
  output logic                     bout,
  input  logic [NPORTS*WIDTH-1:0]  pin_in,
  output logic [NPORTS*WIDTH-1:0]  pin_out,
  output logic [NPORTS*WIDTH-1:0]  pin_oe,
  input  logic                     clr_pend,
  output logic                     irq
);

  localparam int unsigned PW = NPORTS * WIDTH;

  logic [PW-1:0]    latch_q, latch_d;
  logic [PW-1:0]    sync1_q, sync2_q;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] wr_word;
  logic             pend_sel;

  // Write path: byte load or masked bit load into the addressed port; out-of-range sel matches nothing.
  always_comb begin
    latch_d = latch_q;
    wr_word = '0;
    if (en) begin
      for (int unsigned k = 0; k < NPORTS; k++) begin
        if (sel == SELW'(k)) begin
          if (Bb) begin
            wr_word = din;
          end else begin
            wr_word = (latch_q[k*WIDTH +: WIDTH] & ~position) | (position & {WIDTH{bin}});
          end
          latch_d[k*WIDTH +: WIDTH] = wr_word;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q <= '1;
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      latch_q <= latch_d;
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
    end
  end

  // A latch 0 pulls the pad low; a latch 1 releases it to the pull-up.
  assign pin_out = latch_q;
  assign pin_oe  = ~latch_q;

  assign pend_sel = (32'(sel) == NPORTS);

`ifdef PORT_EDGE_IRQ_EN
  logic [PW-1:0] sync3_q;
  logic [PW-1:0] pend_q, pend_d;
  logic [PW-1:0] clr_mask;
  logic          irq_q;

  // Set has priority over a same-cycle write-1-to-clear.
  always_comb begin
    clr_mask = '0;
    if (clr_pend) begin
      for (int unsigned k = 0; k < NPORTS; k++) begin
        if (sel == SELW'(k)) begin
          clr_mask[k*WIDTH +: WIDTH] = din;
        end
      end
    end
    pend_d = (pend_q & ~clr_mask) | (sync3_q & ~sync2_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync3_q <= '1;
      pend_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      pend_q  <= pend_d;
      irq_q   <= |pend_q;
    end
  end

  assign irq = irq_q;
`else
  logic unused_clr_pend;
  assign unused_clr_pend = clr_pend;
  assign irq = 1'b0;
`endif

  // Combinational read; sees pre-write latch contents during a same-cycle write.
  always_comb begin
    src  = '0;
    dout = '0;
    bout = 1'b0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (sel == SELW'(k)) begin
        src = rd_latch ? latch_q[k*WIDTH +: WIDTH] : sync2_q[k*WIDTH +: WIDTH];
      end
    end
    if (oe) begin
      if (Bb) begin
        dout = src;
      end else begin
        bout = |(src & position);
      end
    end
`ifdef PORT_EDGE_IRQ_EN
    if (oe && rd_latch && Bb && pend_sel) begin
      dout = pend_q[WIDTH-1:0];
    end
`else
    if (pend_sel) begin
      dout = '0;
    end
`endif
  end

endmodule

// File: tb/tb_port_bank.sv
// Directed self-checking bench for port_bank (WIDTH=8, NPORTS=4, SELW=3).
module tb_port_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned PW = NP * W;
`ifdef PORT_EDGE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [SW-1:0] sel;
  logic          en, oe, rd_latch, Bb, bin, clr_pend;
  logic [W-1:0]  position, din, dout;
  logic          bout, irq;
  logic [PW-1:0] pin_in, pin_out, pin_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  port_bank #(.WIDTH(W), .NPORTS(NP), .SELW(SW)) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .en(en), .oe(oe),
    .rd_latch(rd_latch), .Bb(Bb), .position(position), .din(din), .bin(bin),
    .dout(dout), .bout(bout), .pin_in(pin_in), .pin_out(pin_out),
    .pin_oe(pin_oe), .clr_pend(clr_pend), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 0; oe = 0; rd_latch = 1; Bb = 1; bin = 0; clr_pend = 0;
    position = '0; din = '0; sel = '0;
    pin_in = '1;
    reset_n = 0;
    repeat (2) tick();
    sel = 3'd2;
    #1;
    check("rst_pin_out", pin_out, 32'hFFFF_FFFF);
    check("rst_pin_oe",  pin_oe,  32'h0);
    check("rst_dout",    32'(dout), 32'h0);
    check("rst_irq",     32'(irq),  32'h0);

    @(negedge clk);
    reset_n = 1;
    oe = 1;
    #1;
    check("rst_latch_p2", 32'(dout), 32'hFF);

    // Byte write, with same-cycle read returning the old value
    sel = 3'd1; din = 8'h5A; en = 1;
    #1;
    check("rmw_pre", 32'(dout), 32'hFF);
    tick();
    en = 0;
    #1;
    check("byte_pin_out", 32'(pin_out[15:8]), 32'h5A);
    check("byte_pin_oe",  32'(pin_oe[15:8]),  32'hA5);
    check("byte_read",    32'(dout),          32'h5A);

    // Bit write of bit 28
    sel = 3'd3; Bb = 0; position = 8'h10; bin = 0; en = 1;
    tick();
    en = 0;
    #1;
    check("bit_pin_out", pin_out, 32'hEFFF_5AFF);
    check("bit_pin_oe",  pin_oe,  32'h1000_A500);
    check("bit_read4",   32'(bout), 32'h0);
    position = 8'h01;
    #1;
    check("bit_read0",   32'(bout), 32'h1);
    position = 8'h11;
    #1;
    check("bit_read_or", 32'(bout), 32'h1);

    // Multi-bit write clears bits 1:0 of port 3
    position = 8'h03; bin = 0; en = 1;
    tick();
    en = 0; Bb = 1;
    #1;
    check("multi_write", 32'(dout), 32'hEC);

    // Out-of-range select
    sel = 3'd5; din = 8'h00; en = 1;
    #1;
    check("oor_read", 32'(dout), 32'h0);
    tick();
    en = 0;
    #1;
    check("oor_nowrite", pin_out, 32'hECFF_5AFF);

    // Pin synchroniser latency
    pin_in[7:0] = 8'h3C;
    sel = 3'd0; rd_latch = 0; Bb = 1; oe = 1;
    tick();
    check("pin_edge1", 32'(dout), 32'hFF);
    tick();
    check("pin_edge2", 32'(dout), 32'h3C);
    Bb = 0; position = 8'h04;
    #1;
    check("pin_bit2", 32'(bout), 32'h1);
    position = 8'h01;
    #1;
    check("pin_bit0", 32'(bout), 32'h0);
    oe = 0; Bb = 1;
    #1;
    check("oe0_dout", 32'(dout), 32'h0);
    check("oe0_bout", 32'(bout), 32'h0);
    repeat (2) tick();
    check("fall_irq", 32'(irq), IRQ ? 32'h1 : 32'h0);
    sel = 3'd4; rd_latch = 1; Bb = 1; oe = 1;
    #1;
    check("fall_pend", 32'(dout), IRQ ? 32'hC3 : 32'h0);

    // Reset in the middle of a write, then a normal write
    pin_in = '1;
    sel = 3'd0; din = 8'h00; en = 1; oe = 0;
    #2;
    reset_n = 0;
    #1;
    check("mid_rst_pin_out", pin_out, 32'hFFFF_FFFF);
    check("mid_rst_irq",     32'(irq), 32'h0);
    tick();
    @(negedge clk);
    reset_n = 1;
    tick();
    en = 0;
    #1;
    check("post_rst_write", pin_out, 32'hFFFF_FF00);

    // Edge interrupt on pin 0
    pin_in[0] = 1'b0;
    sel = 3'd4; rd_latch = 1; Bb = 1; oe = 1;
    tick();
    tick();
    check("irq_e2_pend", 32'(dout), 32'h0);
    tick();
    check("irq_e3_pend", 32'(dout), IRQ ? 32'h01 : 32'h0);
    check("irq_e3_irq",  32'(irq),  32'h0);
    tick();
    check("irq_e4_irq",  32'(irq),  IRQ ? 32'h1 : 32'h0);

    // Clear everything, then re-arm pin 0
    oe = 0; sel = 3'd0; din = 8'hFF; clr_pend = 1;
    tick();
    clr_pend = 0;
    tick();
    check("clr_all_irq", 32'(irq), 32'h0);
    pin_in[0] = 1'b1;
    repeat (3) tick();

    // Set and clear on the same edge: set wins
    pin_in[0] = 1'b0;
    tick();
    tick();
    sel = 3'd0; din = 8'h01; clr_pend = 1;
    tick();
    clr_pend = 0; sel = 3'd4; oe = 1;
    #1;
    check("coll_pend", 32'(dout), IRQ ? 32'h01 : 32'h0);
    tick();
    check("coll_irq", 32'(irq), IRQ ? 32'h1 : 32'h0);

    // Clear alone: irq drops one cycle later
    sel = 3'd0; din = 8'h01; clr_pend = 1; oe = 0;
    tick();
    clr_pend = 0; sel = 3'd4; oe = 1;
    #1;
    check("clr_pend", 32'(dout), 32'h0);
    check("clr_irq_hold", 32'(irq), IRQ ? 32'h1 : 32'h0);
    tick();
    check("clr_irq_drop", 32'(irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
